// File: rtl/bram_sp_arbiter.sv
// Two-port arbiter in front of a single-port BRAM with 1-cycle registered dout.
// Alternating priority on contention; the top address is reserved and returns an error response.
module bram_sp_arbiter #(
  parameter int DATASIZE = 32,
  parameter int ADDRSIZE = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic                a_wr,
  input  logic [ADDRSIZE-1:0] a_addr,
  input  logic [DATASIZE-1:0] a_wdata,
  output logic                a_rsp_valid,
  output logic                a_rsp_err,
  output logic [DATASIZE-1:0] a_rsp_rdata,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic                b_wr,
  input  logic [ADDRSIZE-1:0] b_addr,
  input  logic [DATASIZE-1:0] b_wdata,
  output logic                b_rsp_valid,
  output logic                b_rsp_err,
  output logic [DATASIZE-1:0] b_rsp_rdata,
  output logic                mem_wr,
  output logic [ADDRSIZE-1:0] mem_addr,
  output logic [DATASIZE-1:0] mem_din,
  input  logic [DATASIZE-1:0] mem_dout
);

  typedef enum logic {PRIO_A, PRIO_B} state_t;

  state_t              state, state_nxt;
  logic                grant_a, grant_b, grant, sel_wr, addr_ok;
  logic [ADDRSIZE-1:0] sel_addr, last_addr;
  logic [DATASIZE-1:0] sel_din, last_din;
  logic                rsp_a, rsp_b, rsp_err;

  always_comb begin
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    state_nxt = state;
    sel_wr    = 1'b0;
    sel_addr  = last_addr;
    sel_din   = last_din;
    // Grants are gated by rst_n so nothing is accepted while reset is held.
    if (rst_n) begin
      grant_a = a_valid && (!b_valid || state == PRIO_A);
      grant_b = b_valid && !grant_a;
    end
    if (grant_a) begin
      state_nxt = PRIO_B;
      sel_wr    = a_wr;
      sel_addr  = a_addr;
      sel_din   = a_wdata;
    end else if (grant_b) begin
      state_nxt = PRIO_A;
      sel_wr    = b_wr;
      sel_addr  = b_addr;
      sel_din   = b_wdata;
    end
  end

  assign grant    = grant_a | grant_b;
  // All-ones address is outside the (2**ADDRSIZE-1)-word BRAM.
  assign addr_ok  = ~&sel_addr;
  assign a_ready  = grant_a;
  assign b_ready  = grant_b;
  assign mem_wr   = grant && sel_wr && addr_ok;
  assign mem_addr = sel_addr;
  assign mem_din  = sel_din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PRIO_A;
      last_addr <= '0;
      last_din  <= '0;
      rsp_a     <= 1'b0;
      rsp_b     <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_addr <= sel_addr;
      last_din  <= sel_din;
      rsp_a     <= grant_a;
      rsp_b     <= grant_b;
      rsp_err   <= grant && !addr_ok;
    end
  end

  // BRAM dout lines up with the registered tag; it is write-through, so writes echo wdata.
  assign a_rsp_valid = rsp_a;
  assign a_rsp_err   = rsp_a && rsp_err;
  assign a_rsp_rdata = (rsp_a && !rsp_err) ? mem_dout : '0;
  assign b_rsp_valid = rsp_b;
  assign b_rsp_err   = rsp_b && rsp_err;
  assign b_rsp_rdata = (rsp_b && !rsp_err) ? mem_dout : '0;

endmodule

// File: tb/tb_bram_sp_arbiter.sv
// Directed bench for bram_sp_arbiter with a behavioural write-through BRAM model.
module tb_bram_sp_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_ready, a_wr, a_rsp_valid, a_rsp_err;
  logic [9:0]  a_addr;
  logic [31:0] a_wdata, a_rsp_rdata;
  logic        b_valid, b_ready, b_wr, b_rsp_valid, b_rsp_err;
  logic [9:0]  b_addr;
  logic [31:0] b_wdata, b_rsp_rdata;
  logic        mem_wr;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic [31:0] mem [0:1023];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bram_sp_arbiter #(.DATASIZE(32), .ADDRSIZE(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_err(a_rsp_err), .a_rsp_rdata(a_rsp_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_err(b_rsp_err), .b_rsp_rdata(b_rsp_rdata),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Write-through single-port BRAM, registered output.
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_din;
    mem_dout <= mem_wr ? mem_din : mem[mem_addr];
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    a_valid = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
    b_valid = 0; b_wr = 0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic apply_reset();
    rst_n = 0; idle();
    repeat (2) cyc();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; idle();
    a_valid = 1; b_valid = 1; a_wr = 1; a_addr = 10'h7; a_wdata = 32'h1111_2222;
    #4;
    checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got a=%b b=%b exp 0 0", a_ready, b_ready); end
    checks++; if (mem_wr !== 1'b0 || mem_addr !== 10'h0 || mem_din !== 32'h0) begin errors++; $display("FAIL reset_mem got wr=%b addr=%h din=%h exp 0 0 0", mem_wr, mem_addr, mem_din); end
    cyc();
    checks++; if ({a_rsp_valid, a_rsp_err, b_rsp_valid, b_rsp_err} !== 4'b0 || a_rsp_rdata !== 32'h0 || b_rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp got av=%b ae=%b bv=%b be=%b ad=%h bd=%h exp all 0", a_rsp_valid, a_rsp_err, b_rsp_valid, b_rsp_err, a_rsp_rdata, b_rsp_rdata); end
    idle(); rst_n = 1;
  endtask

  task automatic test_sole();
    a_valid = 1; a_wr = 1; a_addr = 10'h005; a_wdata = 32'hDEADBEEF;
    #4;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errors++; $display("FAIL sole_ready got a=%b b=%b exp 1 0", a_ready, b_ready); end
    checks++; if (mem_wr !== 1'b1 || mem_addr !== 10'h005 || mem_din !== 32'hDEADBEEF) begin errors++; $display("FAIL sole_mem got wr=%b addr=%h din=%h exp 1 005 deadbeef", mem_wr, mem_addr, mem_din); end
    cyc(); idle();
    checks++; if (a_rsp_valid !== 1'b1 || a_rsp_err !== 1'b0 || a_rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sole_rsp got v=%b e=%b d=%h exp 1 0 deadbeef", a_rsp_valid, a_rsp_err, a_rsp_rdata); end
    checks++; if (b_rsp_valid !== 1'b0 || b_rsp_err !== 1'b0 || b_rsp_rdata !== 32'h0) begin errors++; $display("FAIL sole_b_silent got v=%b e=%b d=%h exp 0 0 0", b_rsp_valid, b_rsp_err, b_rsp_rdata); end
    #4;
    checks++; if (mem_wr !== 1'b0 || mem_addr !== 10'h005 || mem_din !== 32'hDEADBEEF) begin errors++; $display("FAIL idle_hold got wr=%b addr=%h din=%h exp 0 005 deadbeef", mem_wr, mem_addr, mem_din); end
    cyc();
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL sole_pulse got %b exp 0", a_rsp_valid); end
    // B alone, also seeds address 6 for the contention test
    b_valid = 1; b_wr = 1; b_addr = 10'h006; b_wdata = 32'hB0B0_0006;
    #4;
    checks++; if (b_ready !== 1'b1 || a_ready !== 1'b0 || mem_wr !== 1'b1) begin errors++; $display("FAIL sole_b_ready got b=%b a=%b wr=%b exp 1 0 1", b_ready, a_ready, mem_wr); end
    cyc(); idle();
    checks++; if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 32'hB0B0_0006 || a_rsp_valid !== 1'b0) begin errors++; $display("FAIL sole_b_rsp got bv=%b bd=%h av=%b exp 1 b0b00006 0", b_rsp_valid, b_rsp_rdata, a_rsp_valid); end
    cyc();
  endtask

  task automatic test_contention();
    logic exp_a;
    apply_reset();
    a_valid = 1; a_wr = 0; a_addr = 10'h005;
    b_valid = 1; b_wr = 0; b_addr = 10'h006;
    for (int i = 0; i < 4; i++) begin
      exp_a = (i % 2 == 0);
      #4;
      checks++; if (a_ready !== exp_a || b_ready !== !exp_a) begin errors++; $display("FAIL contend_ready[%0d] got a=%b b=%b exp %b %b", i, a_ready, b_ready, exp_a, !exp_a); end
      cyc();
      if (i == 3) idle();
      checks++;
      if (exp_a ? (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'hDEADBEEF || b_rsp_valid !== 1'b0 || b_rsp_rdata !== 32'h0)
                : (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 32'hB0B0_0006 || a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'h0)) begin
        errors++; $display("FAIL contend_rsp[%0d] got av=%b ad=%h bv=%b bd=%h exp_a=%b", i, a_rsp_valid, a_rsp_rdata, b_rsp_valid, b_rsp_rdata, exp_a);
      end
    end
  endtask

  task automatic test_invalid();
    b_valid = 1; b_wr = 1; b_addr = 10'h3FF; b_wdata = 32'h5555_5555;
    #4;
    checks++; if (b_ready !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 10'h3FF) begin errors++; $display("FAIL inv_wr got rdy=%b wr=%b addr=%h exp 1 0 3ff", b_ready, mem_wr, mem_addr); end
    cyc();
    b_wr = 0;
    checks++; if (b_rsp_valid !== 1'b1 || b_rsp_err !== 1'b1 || b_rsp_rdata !== 32'h0) begin errors++; $display("FAIL inv_wr_rsp got v=%b e=%b d=%h exp 1 1 0", b_rsp_valid, b_rsp_err, b_rsp_rdata); end
    checks++; if (a_rsp_valid !== 1'b0 || a_rsp_err !== 1'b0) begin errors++; $display("FAIL inv_a_silent got v=%b e=%b exp 0 0", a_rsp_valid, a_rsp_err); end
    #4;
    checks++; if (b_ready !== 1'b1 || mem_wr !== 1'b0) begin errors++; $display("FAIL inv_rd got rdy=%b wr=%b exp 1 0", b_ready, mem_wr); end
    cyc(); idle();
    checks++; if (b_rsp_valid !== 1'b1 || b_rsp_err !== 1'b1 || b_rsp_rdata !== 32'h0) begin errors++; $display("FAIL inv_rd_rsp got v=%b e=%b d=%h exp 1 1 0", b_rsp_valid, b_rsp_err, b_rsp_rdata); end
    cyc();
    checks++; if (b_rsp_valid !== 1'b0 || b_rsp_err !== 1'b0) begin errors++; $display("FAIL inv_err_clear got v=%b e=%b exp 0 0", b_rsp_valid, b_rsp_err); end
  endtask

  task automatic test_back_to_back();
    a_valid = 1; a_wr = 1; a_addr = 10'h010; a_wdata = 32'h12345678;
    #4;
    checks++; if (a_ready !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 10'h010) begin errors++; $display("FAIL b2b_wr got rdy=%b wr=%b addr=%h exp 1 1 010", a_ready, mem_wr, mem_addr); end
    cyc();
    a_wr = 0; a_wdata = 32'h0;
    checks++; if (a_rsp_valid !== 1'b1 || a_rsp_err !== 1'b0 || a_rsp_rdata !== 32'h12345678) begin errors++; $display("FAIL b2b_rsp1 got v=%b e=%b d=%h exp 1 0 12345678", a_rsp_valid, a_rsp_err, a_rsp_rdata); end
    #4;
    checks++; if (a_ready !== 1'b1 || mem_wr !== 1'b0) begin errors++; $display("FAIL b2b_rd got rdy=%b wr=%b exp 1 0", a_ready, mem_wr); end
    cyc(); idle();
    checks++; if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'h12345678) begin errors++; $display("FAIL b2b_rsp2 got v=%b d=%h exp 1 12345678", a_rsp_valid, a_rsp_rdata); end
    cyc();
  endtask

  task automatic test_reset_mid();
    // First grant moves priority to B; the aborted second grant must not stick.
    a_valid = 1; a_wr = 0; a_addr = 10'h005;
    cyc();
    #4;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", a_ready); end
    rst_n = 0;
    #1;
    checks++; if (a_ready !== 1'b0 || a_rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_in_reset got rdy=%b v=%b exp 0 0", a_ready, a_rsp_valid); end
    @(posedge clk); #1;
    checks++; if (a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'h0) begin errors++; $display("FAIL mid_dropped got v=%b d=%h exp 0 0", a_rsp_valid, a_rsp_rdata); end
    rst_n = 1;
    b_valid = 1; b_wr = 0; b_addr = 10'h006;
    #4;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errors++; $display("FAIL mid_prio got a=%b b=%b exp 1 0", a_ready, b_ready); end
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_pulse got %b exp 0", a_rsp_valid); end
    cyc(); idle();
    checks++; if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'hDEADBEEF || b_rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp got av=%b ad=%h bv=%b exp 1 deadbeef 0", a_rsp_valid, a_rsp_rdata, b_rsp_valid); end
    cyc();
  endtask

  initial begin
    rst_n = 0; idle();
    #1;
    test_reset();
    test_sole();
    test_contention();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bram_sp_arbiter.md
BRAM_SP_ARBITER -- requirements
Module: bram_sp_arbiter

Interface
REQ-001 SHALL have parameters: DATASIZE, default 32, data width; ADDRSIZE, default 10, address width.
REQ-002 SHALL have ports (one clock; reset asynchronous, active-low):
 clk  in  1  clock; all state updates on rising edge
 rst_n  in  1  asynchronous active-low reset
 a_valid  in  1  port A request valid
 a_ready  out  1  port A request accepted this cycle
 a_wr  in  1  port A write (1) / read (0)
 a_addr  in  ADDRSIZE  port A address
 a_wdata  in  DATASIZE  port A write data
 a_rsp_valid  out  1  port A response pulse
 a_rsp_err  out  1  port A response error
 a_rsp_rdata  out  DATASIZE  port A response data
 b_*  same nine signals as a_*  port B
 mem_wr  out  1  to single-port BRAM wr
 mem_addr  out  ADDRSIZE  to BRAM addr
 mem_din  out  DATASIZE  to BRAM din
 mem_dout  in  DATASIZE  from BRAM dout (registered, 1-cycle latency, write-through)

Function
REQ-003 SHALL grant at most one port per cycle; handshake completes when x_valid && x_ready.
REQ-004 SHALL use a two-state priority FSM, PRIO_A / PRIO_B; on a cycle where both ports are valid, the port named by the state is granted.
REQ-005 SHALL move the FSM to the other port's priority after every granted cycle: after granting A go to PRIO_B, after B go to PRIO_A; no grant keeps the state.
REQ-006 SHALL grant the sole valid port regardless of priority state.
REQ-007 SHALL compute x_ready combinationally from valids and FSM state; x_ready SHALL NOT depend on x_ready of the other port; x_ready=0 when x_valid=0.
REQ-008 SHALL drive mem_addr, mem_din from the granted port in the grant cycle, and mem_wr = granted wr && address valid; with no grant, mem_wr=0 and mem_addr/mem_din hold the last granted values.
REQ-009 SHALL treat address 2**ADDRSIZE-1 (all ones) as invalid: the BRAM has 2**ADDRSIZE-1 words, so no write is issued to it.
REQ-010 SHALL produce exactly one response per accepted request, on the granted port only, exactly one cycle after the grant cycle; x_rsp_valid is a single-cycle pulse with no backpressure.
REQ-011 SHALL drive x_rsp_rdata = mem_dout and x_rsp_err=0 for a valid address, for both reads and writes (a write returns its write data).
REQ-012 SHALL drive x_rsp_rdata = 0 and x_rsp_err=1 for an invalid address.
REQ-013 SHALL register the response tag (port, err) at grant; the non-responding port SHALL have rsp_valid=0, rsp_err=0 and rsp_rdata=0.
REQ-014 SHALL sustain one accepted request per cycle; back-to-back grants produce back-to-back responses.
REQ-015 Same-address sequencing: a read granted the cycle after a write to the same address SHALL return the new data.

Reset
REQ-016 SHALL, while rst_n=0, force: FSM=PRIO_A; a_ready=b_ready=0; all rsp_valid=0, rsp_err=0, rsp_rdata=0; mem_wr=0; mem_addr=0; mem_din=0.
REQ-017 SHALL drop a response pending at reset assertion, with no pulse after release.
REQ-018 SHALL allow the first grant in the first rising edge after rst_n deasserts.

Verification
REQ-019 Bench SHALL cover:
 - Sole requester: A writes 0xDEADBEEF @0x005 -> a_ready=1 same cycle, mem_wr=1, a_rsp_valid next cycle with rdata 0xDEADBEEF, err=0; B silent.
 - Contention: A and B both read every cycle for 4 cycles from reset -> grants A,B,A,B; responses alternate one cycle later.
 - Invalid address: B writes @0x3FF -> mem_wr=0, b_rsp_err=1, b_rsp_rdata=0; following read @0x3FF likewise err=1.
 - Back-to-back: A writes 0x12345678 @0x010, then reads @0x010 next cycle -> second response 0x12345678.
 - Reset mid-operation: grant A read, assert rst_n=0 before next edge -> no a_rsp_valid; after release FSM=PRIO_A (A wins contention).
